// File: rtl/cacheline_bmem_adapter.sv
// cacheline_bmem_adapter: serves 256b cacheline read/write requests as 4-beat 64b bmem bursts.
// Define CL_ADAPTER_RADDR_CHECK_EN to drop returning beats whose bmem_raddr is not the pending line.
module cacheline_bmem_adapter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] dfp_addr,
    input  logic                  dfp_read,
    input  logic                  dfp_write,
    input  logic [LINE_WIDTH-1:0] dfp_wdata,
    output logic [LINE_WIDTH-1:0] dfp_rdata,
    output logic                  dfp_resp,
    output logic [ADDR_WIDTH-1:0] bmem_addr,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [BEAT_WIDTH-1:0] bmem_wdata,
    input  logic                  bmem_ready,
    input  logic [ADDR_WIDTH-1:0] bmem_raddr,
    input  logic [BEAT_WIDTH-1:0] bmem_rdata,
    input  logic                  bmem_rvalid,
    output logic                  addr_err
);
    localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int CW = $clog2(BEATS);
    localparam int LINE_BYTES = LINE_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_BURST, RESP} state_t;

    state_t                state;
    logic [CW-1:0]         beat_cnt;
    logic [CW-1:0]         beat_nxt;
    logic                  last;
    logic                  beat_ok;
    logic [LINE_WIDTH-1:0] wr_line;
    logic [ADDR_WIDTH-1:0] line_addr;

    assign line_addr = dfp_addr & ~ADDR_WIDTH'(LINE_BYTES - 1);
    assign beat_nxt  = beat_cnt + CW'(1);
    assign last      = beat_cnt == CW'(BEATS - 1);

`ifdef CL_ADAPTER_RADDR_CHECK_EN
    assign beat_ok = bmem_rvalid && bmem_raddr == bmem_addr;

    // bmem_addr still holds the pending line address while beats return
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            addr_err <= 1'b0;
        else if (state == RD_WAIT && bmem_rvalid && !beat_ok)
            addr_err <= 1'b1;
    end
`else
    logic unused_raddr;
    assign unused_raddr = ^bmem_raddr;
    assign beat_ok      = bmem_rvalid;
    assign addr_err     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            wr_line    <= '0;
            dfp_rdata  <= '0;
            dfp_resp   <= 1'b0;
            bmem_addr  <= '0;
            bmem_read  <= 1'b0;
            bmem_write <= 1'b0;
            bmem_wdata <= '0;
        end else begin
            dfp_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (dfp_write) begin
                        state      <= WR_BURST;
                        bmem_addr  <= line_addr;
                        wr_line    <= dfp_wdata;
                        bmem_wdata <= dfp_wdata[BEAT_WIDTH-1:0];
                        bmem_write <= 1'b1;
                    end else if (dfp_read) begin
                        state     <= RD_ISSUE;
                        bmem_addr <= line_addr;
                        bmem_read <= 1'b1;
                    end
                end
                RD_ISSUE: begin
                    if (bmem_ready) begin
                        state     <= RD_WAIT;
                        bmem_read <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (beat_ok) begin
                        dfp_rdata[beat_cnt*BEAT_WIDTH +: BEAT_WIDTH] <= bmem_rdata;
                        beat_cnt <= beat_nxt;
                        state    <= last ? RESP : RD_WAIT;
                        dfp_resp <= last;
                    end
                end
                WR_BURST: begin
                    if (bmem_ready) begin
                        bmem_wdata <= wr_line[beat_nxt*BEAT_WIDTH +: BEAT_WIDTH];
                        beat_cnt   <= beat_nxt;
                        state      <= last ? RESP : WR_BURST;
                        dfp_resp   <= last;
                        bmem_write <= !last;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cacheline_bmem_adapter.sv
// tb_cacheline_bmem_adapter: vector, corner and random checks against a line-level model of memory and master
module tb_cacheline_bmem_adapter;
  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;
  logic         addr_err;
  int           n_cmp = 0;
  int           n_err = 0;
  logic [255:0] last_rd;
  logic         err_m;
  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] line;
    int           gap;
    int           lat;
  } vec_t;
  vec_t tbl[6];
  always #5 clk = ~clk;
  cacheline_bmem_adapter dut (
    .clk(clk), .rst(rst),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid), .addr_err(addr_err)
  );
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [255:0] rnd_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction
  task automatic txn(input string name, input logic wr, input logic both, input logic [31:0] addr,
                     input logic [255:0] line, input int gap, input logic rnd, input int bad_at,
                     input int exp_lat);
    logic [31:0] la;
    int          k, stalls, cyc;
    logic        issued, acc, inj;
    la = addr & 32'hffff_ffe0;
    k = 0; stalls = 0; cyc = 1; issued = 0; acc = 0; inj = 0;
    dfp_addr  = addr;
    dfp_write = wr;
    dfp_read  = !wr || both;
    dfp_wdata = wr ? line : rnd_line();
    tick();
    while (!dfp_resp && cyc < 200) begin
      chk({name, " cross request"}, wr ? bmem_read : bmem_write, 1'b0);
      bmem_ready = rnd ? ($urandom_range(0, 3) != 0)
                       : !((wr ? (bmem_write && k == 1) : bmem_read) && stalls < gap);
      if (!rnd && !bmem_ready) stalls++;
      if (bmem_write) begin
        chk({name, " write addr"}, bmem_addr, la);
        if (k < 4) chk({name, " wdata"}, bmem_wdata, line[k*64 +: 64]);
        else chk({name, " extra beat"}, bmem_write, 1'b0);
        if (bmem_ready) k++;
      end
      if (bmem_read) begin
        chk({name, " read addr"}, bmem_addr, la);
        chk({name, " rdata held"}, dfp_rdata, last_rd);
        acc = bmem_ready;
      end
      bmem_rvalid = rnd ? ($urandom_range(0, 1) == 1) : (issued && k < 4);
      bmem_rdata  = {$urandom, $urandom};
      bmem_raddr  = la ^ 32'h40;
      if (issued && k < 4 && bmem_rvalid) begin
        if (k == bad_at && !inj) begin
          inj = 1;
          bmem_raddr = 32'h0BAD_0000;
`ifndef CL_ADAPTER_RADDR_CHECK_EN
          bmem_rdata = line[k*64 +: 64];
          k++;
`endif
        end else begin
          bmem_raddr = la;
          bmem_rdata = line[k*64 +: 64];
          k++;
        end
      end
      tick();
      cyc++;
      issued = issued | acc;
    end
    bmem_rvalid = 0;
    bmem_ready  = 0;
    dfp_read    = 0;
    dfp_write   = 0;
    if (!dfp_resp) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s timeout: no dfp_resp within 200 cycles", name);
    end else begin
      if (exp_lat > 0) chk({name, " latency"}, cyc + 1, exp_lat);
      chk({name, " beats"}, k, 4);
      if (!wr) last_rd = line;
      chk({name, " rdata"}, dfp_rdata, last_rd);
      tick();
      chk({name, " resp pulse"}, dfp_resp, 1'b0);
      chk({name, " bus idle"}, {bmem_read, bmem_write}, 2'b00);
`ifdef CL_ADAPTER_RADDR_CHECK_EN
      if (inj) err_m = 1;
`endif
      chk({name, " addr_err"}, addr_err, err_m);
    end
  endtask
  initial begin
    logic [255:0] ln;
    rst = 1; dfp_addr = 0; dfp_read = 0; dfp_write = 0; dfp_wdata = 0;
    bmem_ready = 0; bmem_raddr = 0; bmem_rdata = 0; bmem_rvalid = 0;
    last_rd = 0; err_m = 0;
    tbl[0] = '{1'b0, 32'h1000_0024, {64'hA3, 64'hA2, 64'hA1, 64'hA0}, 0, 7};
    tbl[1] = '{1'b1, 32'h2000_0040, {64'hD3, 64'hD2, 64'hD1, 64'hD0}, 0, 6};
    tbl[2] = '{1'b1, 32'h2000_0040, {64'hD3, 64'hD2, 64'hD1, 64'hD0}, 2, 8};
    tbl[3] = '{1'b0, 32'h0000_001f, {64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210,
                                     64'h5555_aaaa_5555_aaaa, 64'h0f0f_0f0f_f0f0_f0f0}, 3, 10};
    tbl[4] = '{1'b1, 32'hffff_ffe7, {64'h1, 64'h8000_0000_0000_0000, 64'hffff, 64'h0}, 1, 7};
    tbl[5] = '{1'b0, 32'hffff_ffff, {256{1'b1}}, 0, 7};
    #12;
    chk("reset rdata", dfp_rdata, 256'h0);
    chk("reset ctl", {dfp_resp, bmem_read, bmem_write, addr_err}, 4'h0);
    chk("reset bmem", {bmem_addr, bmem_wdata}, 96'h0);
    @(negedge clk);
    rst = 0;
    tick();
    for (int i = 0; i < 6; i++)
      txn($sformatf("vec%0d", i), tbl[i].wr, 1'b0, tbl[i].addr, tbl[i].line, tbl[i].gap, 1'b0, -1, tbl[i].lat);
    bmem_rvalid = 1;
    for (int i = 0; i < 3; i++) begin
      bmem_rdata = {$urandom, $urandom};
      tick();
      chk("idle rvalid ignored", {dfp_resp, bmem_read, bmem_write}, 3'b000);
    end
    bmem_rvalid = 0;
    chk("idle rdata kept", dfp_rdata, last_rd);
    txn("rd+wr write first", 1'b1, 1'b1, 32'h4000_0080, rnd_line(), 0, 1'b0, -1, 6);
    txn("rd+wr read later", 1'b0, 1'b0, 32'h4000_0080, rnd_line(), 0, 1'b0, -1, 7);
    ln = rnd_line();
    dfp_addr = 32'h3000_0100;
    dfp_read = 1;
    tick();
    bmem_ready = 1;
    tick();
    bmem_ready  = 0;
    bmem_rvalid = 1;
    bmem_raddr  = 32'h3000_0100;
    bmem_rdata  = 64'h1111;
    tick();
    bmem_rdata = 64'h2222;
    tick();
    bmem_rvalid = 0;
    chk("partial line", dfp_rdata[127:0], {64'h2222, 64'h1111});
    #2 rst = 1;
    #1;
    chk("mid reset rdata", dfp_rdata, 256'h0);
    chk("mid reset ctl", {dfp_resp, bmem_read, bmem_write, addr_err}, 4'h0);
    chk("mid reset bmem", {bmem_addr, bmem_wdata}, 96'h0);
    #2 rst = 0;
    dfp_read = 0;
    last_rd = 0;
    err_m = 0;
    tick();
    txn("post reset read", 1'b0, 1'b0, 32'h3000_0100, ln, 0, 1'b0, -1, 7);
    txn("bad raddr beat", 1'b0, 1'b0, 32'h5000_0060, rnd_line(), 0, 1'b0, 2, 0);
    txn("after bad raddr", 1'b0, 1'b0, 32'h5000_00a0, rnd_line(), 1, 1'b1, -1, 0);
    for (int i = 0; i < 40; i++)
      txn("random", 1'($urandom_range(0, 1)), 1'b0, $urandom, rnd_line(), 0, 1'b1, -1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
